// File: rtl/periph_bus_arbiter.sv
// Round-robin two-master arbiter driving one peripheral slave with a sel/enable (setup, access) handshake.
// Latency: req seen in IDLE -> ack 3 cycles later with a ready slave; masters hold req until ack, hung accesses time out.
module periph_bus_arbiter #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_sel_o,
    output logic              s_enable_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;     // 1: m1 owned the previous transfer
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         grant_q, grant_d;
    logic               sel_q, sel_d;
    logic               en_q, en_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               ack0_q, ack0_d, ack1_q, ack1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0]  rd0_q, rd0_d, rd1_q, rd1_d;

    logic               pick_m1;
    logic               finish;
    logic               fin_err;
    logic [DATA_W-1:0]  fin_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            grant_q <= '0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        en_d     = en_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        // On a tie the master that did not own the last transfer wins.
        pick_m1  = m1_req_i && (!m0_req_i || !last_q);
        finish   = 1'b0;
        fin_err  = 1'b0;
        fin_data = s_rdata_i;

        case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    we_d    = pick_m1 ? m1_we_i    : m0_we_i;
                    addr_d  = pick_m1 ? m1_addr_i  : m0_addr_i;
                    wdata_d = pick_m1 ? m1_wdata_i : m0_wdata_i;
                    sel_d   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                en_d    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (s_ack_i) begin
                    finish = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    finish   = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = ERR_DATA;
                end
            end
            DONE: begin
                last_d  = grant_q[1];
                cnt_d   = '0;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d = DONE;
            sel_d   = 1'b0;
            en_d    = 1'b0;
            we_d    = 1'b0;
            ack0_d  = grant_q[0];
            ack1_d  = grant_q[1];
            err0_d  = grant_q[0] && fin_err;
            err1_d  = grant_q[1] && fin_err;
            if (!we_q && grant_q[0]) rd0_d = fin_data;
            if (!we_q && grant_q[1]) rd1_d = fin_data;
        end
    end

    assign m0_rdata_o = rd0_q;
    assign m0_ack_o   = ack0_q;
    assign m0_err_o   = err0_q;
    assign m1_rdata_o = rd1_q;
    assign m1_ack_o   = ack1_q;
    assign m1_err_o   = err1_q;
    assign s_sel_o    = sel_q;
    assign s_enable_o = en_q;
    assign s_we_o     = we_q;
    assign s_addr_o   = addr_q;
    assign s_wdata_o  = wdata_q;
    assign grant_o    = grant_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized bench for periph_bus_arbiter against a transfer-level reference model.
module tb_periph_bus_arbiter;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam int          NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_sel_o, s_enable_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_wdata_o;
    logic [DW-1:0] s_rdata_i;
    logic          s_ack_i;
    logic [1:0]    grant_o;

    always #5 clk = ~clk;

    periph_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
        .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
        .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_sel_o(s_sel_o), .s_enable_o(s_enable_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a transfer is "in flight" from grant to completion.
    // acc_n = 0 during the setup cycle, then counts access cycles 1..TO.
    bit          busy, in_done, owner, last, x_we, e_err;
    int          acc_n;
    logic [31:0] e_addr, e_wdata, e_rd [2];

    task automatic model_step();
        if (!rst) begin
            busy = 0; in_done = 0; acc_n = 0; owner = 0; last = 1; x_we = 0; e_err = 0;
            e_addr = '0; e_wdata = '0; e_rd[0] = '0; e_rd[1] = '0;
        end else if (in_done) begin
            in_done = 0; busy = 0; e_err = 0; last = owner;
        end else if (!busy) begin
            if (req[0] || req[1]) begin
                owner   = (req[0] && req[1]) ? !last : req[1];
                busy    = 1;
                acc_n   = 0;
                x_we    = we[owner];
                e_addr  = addr[owner];
                e_wdata = wdata[owner];
            end
        end else if (acc_n == 0) begin
            acc_n = 1;
        end else if (s_ack_i || acc_n == TO) begin
            in_done = 1;
            e_err   = !s_ack_i;
            if (!x_we) e_rd[owner] = s_ack_i ? s_rdata_i : ERRD;
        end else begin
            acc_n++;
        end
    endtask

    task automatic check_outputs();
        bit act;
        act = busy && !in_done;
        chk("grant",     grant_o, busy ? (owner ? 2'b10 : 2'b01) : 2'b00);
        chk("slave_ctl", {s_sel_o, s_enable_o, s_we_o}, {act, act && (acc_n >= 1), act && x_we});
        chk("s_addr",    s_addr_o, e_addr);
        chk("s_wdata",   s_wdata_o, e_wdata);
        chk("m0_ack_err", {m0_ack_o, m0_err_o}, {in_done && !owner, in_done && !owner && e_err});
        chk("m1_ack_err", {m1_ack_o, m1_err_o}, {in_done && owner, in_done && owner && e_err});
        chk("m0_rdata",  m0_rdata_o, e_rd[0]);
        chk("m1_rdata",  m1_rdata_o, e_rd[1]);
    endtask

    task automatic drive_inputs(input int c);
        int  phase;
        bit  owning;
        phase = c / 1000;
        rst   = (c < 3) ? 1'b0 : (phase == 3) ? ($urandom_range(0, 39) != 0) : 1'b1;
        for (int m = 0; m < 2; m++) begin
            owning = busy && !in_done && (owner == m);
            if (in_done && owner == m)  req[m] = $urandom_range(0, 1);
            else if (!req[m])           req[m] = ($urandom_range(0, 2) == 0);
            else if (owning)            req[m] = ($urandom_range(0, 7) != 0);
            we[m]    = $urandom_range(0, 1);
            addr[m]  = $urandom;
            wdata[m] = $urandom;
        end
        s_rdata_i = $urandom;
        case (phase)
            0:       s_ack_i = ($urandom_range(0, 9) < 6);
            1:       s_ack_i = 1'b0;
            2:       s_ack_i = busy && !in_done && (acc_n == TO);
            default: s_ack_i = ($urandom_range(0, 1) == 1);
        endcase
        if (c >= 100 && c < 300) begin
            req[0] = 1'b1; req[1] = 1'b1; s_ack_i = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b0; s_ack_i = 1'b0; s_rdata_i = '0;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
        end
        model_step();
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            check_outputs();
            drive_inputs(c);
            model_step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
